// File: rtl/cd_pkg.sv
// Shared definitions for the CDBUS CSR DMA engine: CSR map, control bits, FSM states.
package cd_pkg;

  // CSR addresses of the controller's RAM windows and control registers
  localparam logic [4:0] CSR_RX      = 5'h14;
  localparam logic [4:0] CSR_TX      = 5'h15;
  localparam logic [4:0] CSR_RX_CTRL = 5'h16;
  localparam logic [4:0] CSR_TX_CTRL = 5'h17;

  // RX_CTRL / TX_CTRL bit positions: bit0 resets the RAM pointer,
  // bit1 is rd_done on RX and buffer switch on TX
  localparam int CTRL_RST_BIT  = 0;
  localparam int CTRL_DONE_BIT = 1;

  localparam logic [7:0] CTRL_RST  = 8'(1 << CTRL_RST_BIT);
  localparam logic [7:0] CTRL_DONE = 8'(1 << CTRL_DONE_BIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_RST,
    ST_RX_RD,
    ST_RX_DONE,
    ST_RX_COOL,
    ST_TX_RST,
    ST_TX_WR,
    ST_TX_SW
  } state_e;

  // Which direction was granted most recently, for round-robin between RX and TX
  typedef enum logic {
    SIDE_RX = 1'b0,
    SIDE_TX = 1'b1
  } side_e;

endpackage

// File: rtl/cd_csr_dma.sv
// Frame mover mastering the controller CSR port: drains RX frames onto a byte
// stream, loads TX frames from a byte stream, and lets a host through between frames.
module cd_csr_dma
  import cd_pkg::*;
#(
  parameter int RX_HDR_LEN  = 3,
  parameter int RX_COOLDOWN = 2,
  parameter int MAX_FRAME   = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] h_address,
  input  logic       h_read,
  input  logic       h_write,
  input  logic [7:0] h_writedata,
  output logic [7:0] h_readdata,
  output logic       h_waitrequest,
  output logic [4:0] m_address,
  output logic       m_read,
  output logic       m_write,
  output logic [7:0] m_writedata,
  input  logic [7:0] m_readdata,
  input  logic       rx_pending,
  input  logic       tx_pending,
  input  logic       en_rx,
  input  logic       en_tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_last,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_overflow,
  output logic [1:0] frame_done
);

  localparam logic [8:0] HDR_W     = 9'(RX_HDR_LEN);
  localparam logic [8:0] MAX_W     = 9'(MAX_FRAME);
  localparam logic [8:0] COOL_LAST = 9'(RX_COOLDOWN - 1);

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [8:0] total_q, total_d;
  side_e      last_q, last_d;
  logic       ovf_q, ovf_d;

  logic       rx_req, tx_req;
  logic [8:0] hdr_total;
  logic [8:0] rx_total;

  assign h_readdata = m_readdata;
  assign rx_req     = en_rx & rx_pending;
  assign tx_req     = en_tx & ~tx_pending & tx_valid;

  // Frame length in force for the current read: header plus payload, capped to one page,
  // taken straight off the bus when the length byte is being read
  always_comb begin
    hdr_total = HDR_W + {1'b0, m_readdata};
    if (hdr_total > MAX_W) hdr_total = MAX_W;
    rx_total = (cnt_q == HDR_W - 9'd1) ? hdr_total : total_q;
  end

  // State, counters, round-robin pointer and overflow latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      total_q <= '0;
      last_q  <= SIDE_TX;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and CSR/stream outputs; every engine CSR access completes in one cycle
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    total_d       = total_q;
    last_d        = last_q;
    ovf_d         = ovf_q;
    m_address     = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_writedata   = '0;
    h_waitrequest = h_read | h_write;
    rx_data       = '0;
    rx_valid      = 1'b0;
    rx_last       = 1'b0;
    tx_ready      = 1'b0;
    tx_overflow   = 1'b0;
    frame_done    = '0;

    unique case (state_q)
      ST_IDLE: begin
        h_waitrequest = 1'b0;
        if (h_read | h_write) begin
          m_address   = h_address;
          m_read      = h_read;
          m_write     = h_write;
          m_writedata = h_writedata;
        end else if (rx_req && (!tx_req || last_q == SIDE_TX)) begin
          state_d = ST_RX_RST;
          last_d  = SIDE_RX;
        end else if (tx_req) begin
          state_d = ST_TX_RST;
          last_d  = SIDE_TX;
        end
      end

      ST_RX_RST: begin
        m_write     = 1'b1;
        m_address   = CSR_RX_CTRL;
        m_writedata = CTRL_RST;
        cnt_d       = '0;
        total_d     = MAX_W;
        state_d     = ST_RX_RD;
      end

      ST_RX_RD: begin
        // A stalled sink suppresses the read so no byte is popped from RX RAM
        if (rx_ready) begin
          m_read    = 1'b1;
          m_address = CSR_RX;
          rx_valid  = 1'b1;
          rx_data   = m_readdata;
          cnt_d     = cnt_q + 9'd1;
          total_d   = rx_total;
          if (cnt_q == rx_total - 9'd1) begin
            rx_last = 1'b1;
            state_d = ST_RX_DONE;
          end
        end
      end

      ST_RX_DONE: begin
        m_write       = 1'b1;
        m_address     = CSR_RX_CTRL;
        m_writedata   = CTRL_DONE;
        frame_done[0] = 1'b1;
        cnt_d         = '0;
        state_d       = (RX_COOLDOWN == 0) ? ST_IDLE : ST_RX_COOL;
      end

      ST_RX_COOL: begin
        // Give the controller time to drop rx_pending before it is sampled again
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == COOL_LAST) state_d = ST_IDLE;
      end

      ST_TX_RST: begin
        m_write     = 1'b1;
        m_address   = CSR_TX_CTRL;
        m_writedata = CTRL_RST;
        cnt_d       = '0;
        state_d     = ST_TX_WR;
      end

      ST_TX_WR: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          if (cnt_q < MAX_W) begin
            m_write     = 1'b1;
            m_address   = CSR_TX;
            m_writedata = tx_data;
            cnt_d       = cnt_q + 9'd1;
          end else begin
            ovf_d = 1'b1;
          end
          if (tx_last) state_d = ST_TX_SW;
        end
      end

      ST_TX_SW: begin
        m_write       = 1'b1;
        m_address     = CSR_TX_CTRL;
        m_writedata   = CTRL_DONE;
        frame_done[1] = 1'b1;
        tx_overflow   = ovf_q;
        ovf_d         = 1'b0;
        state_d       = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
